// File: rtl/mv_pkg.sv
// Shared definitions for the background redraw path: game-state encodings,
// screen geometry, bus widths and the sequencer state encoding.
package mv_pkg;

   localparam int unsigned SCREEN_W = 240;
   localparam int unsigned SCREEN_H = 240;
   localparam int unsigned COLOR_W  = 3;
   localparam int unsigned STATE_W  = 4;
   localparam int unsigned X_W      = 9;
   localparam int unsigned Y_W      = 8;

   typedef enum logic [STATE_W-1:0] {
      DRAW_INITIAL   = 4'd0,
      WAIT_START     = 4'd1,
      DRAW_BOARD     = 4'd2,
      PLAYER1_TURN   = 4'd3,
      PLAYER1_MOVE   = 4'd4,
      PLAYER2_TURN   = 4'd5,
      PLAYER2_MOVE   = 4'd6,
      CHECK_WIN      = 4'd7,
      PLAYER1_WINS   = 4'd8,
      PLAYER2_WINS   = 4'd9,
      DRAW_GAME      = 4'd10,
      FINISHED_GAME  = 4'd11
   } game_state_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/coord_delay_line.sv
// Shift register carrying {valid, X, Y} alongside the fetcher's ROM latency so
// the plot strobe and coordinates line up with the returned colour.
module coord_delay_line
   import mv_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           in_valid,
   input  logic [X_W-1:0] in_x,
   input  logic [Y_W-1:0] in_y,
   output logic           out_valid,
   output logic [X_W-1:0] out_x,
   output logic [Y_W-1:0] out_y
);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [X_W-1:0]   x_q [DEPTH];
   logic [X_W-1:0]   x_d [DEPTH];
   logic [Y_W-1:0]   y_q [DEPTH];
   logic [Y_W-1:0]   y_d [DEPTH];

   always_comb begin
      valid_d    = valid_q;
      x_d        = x_q;
      y_d        = y_q;
      valid_d[0] = in_valid;
      x_d[0]     = in_x;
      y_d[0]     = in_y;
      for (int i = 1; i < int'(DEPTH); i++) begin
         valid_d[i] = valid_q[i-1];
         x_d[i]     = x_q[i-1];
         y_d[i]     = y_q[i-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_x     = x_q[DEPTH-1];
   assign out_y     = y_q[DEPTH-1];

endmodule

// File: rtl/background_redraw_sequencer.sv
// Sweeps every background pixel through the fetcher on a start request or a
// game-state change and forwards latency-aligned plot strobes to the VGA adapter.
module background_redraw_sequencer
   import mv_pkg::*;
#(
   parameter int unsigned WIDTH       = SCREEN_W,
   parameter int unsigned HEIGHT      = SCREEN_H,
   parameter int unsigned ROM_LATENCY = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [STATE_W-1:0]  gameState,
   output logic [STATE_W-1:0]  fetchState,
   output logic [X_W-1:0]      fetchX,
   output logic [Y_W-1:0]      fetchY,
   input  logic [COLOR_W-1:0]  fetchColor,
   output logic                plot,
   output logic [X_W-1:0]      vgaX,
   output logic [Y_W-1:0]      vgaY,
   output logic [COLOR_W-1:0]  vgaColor,
   output logic                busy,
   output logic                done
);

   localparam logic [X_W-1:0] X_LAST     = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0] Y_LAST     = Y_W'(HEIGHT - 1);
   localparam logic [1:0]     DRAIN_LAST = 2'(ROM_LATENCY - 1);

   seq_state_e         state_q, state_d;
   logic [STATE_W-1:0] fetch_state_q, fetch_state_d;
   logic [STATE_W-1:0] prev_state_q, prev_state_d;
   logic               pending_q, pending_d;
   logic [X_W-1:0]     fetch_x_q, fetch_x_d;
   logic [Y_W-1:0]     fetch_y_q, fetch_y_d;
   logic [1:0]         drain_cnt_q, drain_cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               issue_valid;

   always_comb begin
      state_d       = state_q;
      fetch_state_d = fetch_state_q;
      prev_state_d  = prev_state_q;
      pending_d     = pending_q;
      fetch_x_d     = fetch_x_q;
      fetch_y_d     = fetch_y_q;
      drain_cnt_d   = drain_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (start || (gameState != prev_state_q) || pending_q) begin
               fetch_state_d = gameState;
               prev_state_d  = gameState;
               pending_d     = 1'b0;
               fetch_x_d     = '0;
               fetch_y_d     = '0;
               state_d       = S_SWEEP;
            end
         end
         S_SWEEP: begin
            if (fetch_x_q == X_LAST) begin
               fetch_x_d = '0;
               if (fetch_y_q == Y_LAST) begin
                  fetch_y_d   = '0;
                  drain_cnt_d = DRAIN_LAST;
                  state_d     = S_DRAIN;
               end else begin
                  fetch_y_d = fetch_y_q + Y_W'(1);
               end
            end else begin
               fetch_x_d = fetch_x_q + X_W'(1);
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q == 2'd0) begin
               state_d = S_DONE;
            end else begin
               drain_cnt_d = drain_cnt_q - 2'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Changes seen mid-frame collapse into a single follow-up redraw.
      if ((state_q != S_IDLE) && (gameState != prev_state_q)) begin
         pending_d    = 1'b1;
         prev_state_d = gameState;
      end

      busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         fetch_state_q <= '0;
         prev_state_q  <= gameState;
         pending_q     <= 1'b0;
         fetch_x_q     <= '0;
         fetch_y_q     <= '0;
         drain_cnt_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_state_q <= fetch_state_d;
         prev_state_q  <= prev_state_d;
         pending_q     <= pending_d;
         fetch_x_q     <= fetch_x_d;
         fetch_y_q     <= fetch_y_d;
         drain_cnt_q   <= drain_cnt_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign issue_valid = (state_q == S_SWEEP);

   coord_delay_line #(
      .DEPTH (ROM_LATENCY)
   ) u_delay (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (issue_valid),
      .in_x      (fetch_x_q),
      .in_y      (fetch_y_q),
      .out_valid (plot),
      .out_x     (vgaX),
      .out_y     (vgaY)
   );

   assign fetchState = fetch_state_q;
   assign fetchX     = fetch_x_q;
   assign fetchY     = fetch_y_q;
   assign vgaColor   = fetchColor;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_background_redraw_sequencer.sv
// Bench for background_redraw_sequencer: a 4x3 frame at ROM latency 1 and 2
// side by side, checked every cycle against a frame-timing reference model.
module tb_background_redraw_sequencer;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] gs = 4'd0;

   logic [3:0] fs_o   [2];
   logic [8:0] fx     [2];
   logic [7:0] fy     [2];
   logic [2:0] fc     [2];
   logic       plot_o [2];
   logic [8:0] vx     [2];
   logic [7:0] vy     [2];
   logic [2:0] vc     [2];
   logic       busy_o [2];
   logic       done_o [2];
   logic [2:0] fc_s0;

   background_redraw_sequencer #(.WIDTH(W), .HEIGHT(H), .ROM_LATENCY(1)) u_dut1 (
      .clock(clk), .reset(rst), .start(start), .gameState(gs),
      .fetchState(fs_o[0]), .fetchX(fx[0]), .fetchY(fy[0]), .fetchColor(fc[0]),
      .plot(plot_o[0]), .vgaX(vx[0]), .vgaY(vy[0]), .vgaColor(vc[0]),
      .busy(busy_o[0]), .done(done_o[0]));

   background_redraw_sequencer #(.WIDTH(W), .HEIGHT(H), .ROM_LATENCY(2)) u_dut2 (
      .clock(clk), .reset(rst), .start(start), .gameState(gs),
      .fetchState(fs_o[1]), .fetchX(fx[1]), .fetchY(fy[1]), .fetchColor(fc[1]),
      .plot(plot_o[1]), .vgaX(vx[1]), .vgaY(vy[1]), .vgaColor(vc[1]),
      .busy(busy_o[1]), .done(done_o[1]));

   // Fetcher models: colour = (X+Y)&7, one and two cycles of ROM latency
   always @(posedge clk) begin
      if (rst) begin
         fc[0] <= 3'd0;
         fc_s0 <= 3'd0;
         fc[1] <= 3'd0;
      end else begin
         fc[0] <= 3'(fx[0] + 9'(fy[0]));
         fc_s0 <= 3'(fx[1] + 9'(fy[1]));
         fc[1] <= fc_s0;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, idx, $time, got, exp);
      end
   endtask

   // Reference model: frame-level bookkeeping by trigger time
   int         cyc = 0;
   bit         ok = 1'b0;
   bit         act   [2];
   int         t0    [2];
   logic [3:0] mfs   [2];
   logic [3:0] mprev [2];
   bit         mpend [2];
   int         dcnt  [2];

   always @(posedge clk) begin
      int lat, j;
      bit idle;
      for (int i = 0; i < 2; i++) begin
         lat = i + 1;
         j   = cyc - t0[i];
         if (rst) begin
            act[i]   = 1'b0;
            mpend[i] = 1'b0;
            mprev[i] = gs;
            mfs[i]   = 4'd0;
         end else if (ok) begin
            idle = !act[i] || (j >= N + lat + 2);
            if (idle) begin
               if (start || gs != mprev[i] || mpend[i]) begin
                  act[i]   = 1'b1;
                  t0[i]    = cyc;
                  mfs[i]   = gs;
                  mprev[i] = gs;
                  mpend[i] = 1'b0;
               end
            end else if (gs != mprev[i]) begin
               mpend[i] = 1'b1;
               mprev[i] = gs;
            end
         end
      end
      if (rst) ok = 1'b1;
      cyc++;
   end

   always @(negedge clk) begin
      int lat, j, p;
      bit e_busy, e_plot, e_done, sweep;
      if (ok) begin
         for (int i = 0; i < 2; i++) begin
            lat    = i + 1;
            j      = cyc - 1 - t0[i];
            p      = j - lat;
            e_busy = act[i] && j <= N + lat - 1;
            e_plot = act[i] && j >= lat && j <= N + lat - 1;
            e_done = act[i] && j == N + lat;
            sweep  = act[i] && j < N;
            chk("busy", i, 32'(busy_o[i]), 32'(e_busy));
            chk("plot", i, 32'(plot_o[i]), 32'(e_plot));
            chk("done", i, 32'(done_o[i]), 32'(e_done));
            chk("fetchState", i, 32'(fs_o[i]), 32'(mfs[i]));
            chk("fetchX", i, 32'(fx[i]), sweep ? 32'(j % W) : 32'd0);
            chk("fetchY", i, 32'(fy[i]), sweep ? 32'(j / W) : 32'd0);
            chk("vgaX", i, 32'(vx[i]), e_plot ? 32'(p % W) : 32'd0);
            chk("vgaY", i, 32'(vy[i]), e_plot ? 32'(p / W) : 32'd0);
            if (e_plot) chk("vgaColor", i, 32'(vc[i]), 32'((p % W + p / W) & 7));
            if (done_o[i] === 1'b1) dcnt[i]++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic chk_window(input string name, input int b0, input int b1, input int exp_done, input logic [3:0] exp_fs);
      chk({name, "_done"}, 0, 32'(dcnt[0] - b0), 32'(exp_done));
      chk({name, "_done"}, 1, 32'(dcnt[1] - b1), 32'(exp_done));
      for (int i = 0; i < 2; i++) begin
         chk({name, "_fs"}, i, 32'(fs_o[i]), 32'(exp_fs));
         chk({name, "_idle"}, i, 32'(busy_o[i]), 32'd0);
      end
   endtask

   typedef struct {
      bit         rst;
      bit         start;
      logic [3:0] gs;
      int         hold;
      int         exp_done;
      logic [3:0] exp_fs;
   } vec_t;

   vec_t tbl [5];
   int   b0, b1;

   initial begin
      tbl[0] = '{rst: 1'b1, start: 1'b0, gs: 4'd1, hold: 3,  exp_done: 0, exp_fs: 4'd0};
      tbl[1] = '{rst: 1'b0, start: 1'b1, gs: 4'd1, hold: 30, exp_done: 1, exp_fs: 4'd1};
      tbl[2] = '{rst: 1'b0, start: 1'b0, gs: 4'd3, hold: 30, exp_done: 1, exp_fs: 4'd3};
      tbl[3] = '{rst: 1'b0, start: 1'b1, gs: 4'd4, hold: 30, exp_done: 1, exp_fs: 4'd4};
      tbl[4] = '{rst: 1'b0, start: 1'b0, gs: 4'd4, hold: 10, exp_done: 0, exp_fs: 4'd4};

      tick(2);
      rst = 1'b0;
      tick(1);

      foreach (tbl[k]) begin
         b0 = dcnt[0];
         b1 = dcnt[1];
         rst = tbl[k].rst;
         start = tbl[k].start;
         gs = tbl[k].gs;
         tick(1);
         rst = 1'b0;
         start = 1'b0;
         tick(tbl[k].hold);
         chk_window($sformatf("vec%0d", k), b0, b1, tbl[k].exp_done, tbl[k].exp_fs);
      end

      // Two changes during a frame: old state held, one follow-up frame
      b0 = dcnt[0]; b1 = dcnt[1];
      gs = 4'd3;
      tick(5);
      gs = 4'd5;
      tick(2);
      gs = 4'd7;
      tick(1);
      chk("midframe_fs", 0, 32'(fs_o[0]), 32'd3);
      chk("midframe_fs", 1, 32'(fs_o[1]), 32'd3);
      tick(60);
      chk_window("changes", b0, b1, 2, 4'd7);

      // Start while busy is dropped
      b0 = dcnt[0]; b1 = dcnt[1];
      pulse_start();
      tick(5);
      pulse_start();
      tick(40);
      chk_window("busy_start", b0, b1, 1, 4'd7);

      // Reset mid-frame aborts without done, then a clean frame follows
      b0 = dcnt[0]; b1 = dcnt[1];
      pulse_start();
      tick(6);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("rst_plot", i, 32'(plot_o[i]), 32'd0);
         chk("rst_all", i, {fs_o[i], 3'(fx[i]), 3'(fy[i]), 3'(vx[i]), 3'(vy[i]), vc[i], busy_o[i], done_o[i]}, 32'd0);
      end
      tick(30);
      chk_window("rst_abort", b0, b1, 0, 4'd0);
      b0 = dcnt[0]; b1 = dcnt[1];
      pulse_start();
      tick(30);
      chk_window("rst_restart", b0, b1, 1, 4'd7);

      // Randomised traffic against the model
      repeat (600) begin
         start = ($urandom_range(19) == 0);
         if ($urandom_range(29) == 0) gs = 4'($urandom_range(11));
         rst = ($urandom_range(249) == 0);
         tick(1);
      end
      rst = 1'b0;
      start = 1'b0;
      tick(40);
      chk("final_idle", 0, 32'(busy_o[0]), 32'd0);
      chk("final_idle", 1, 32'(busy_o[1]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
